// File: rtl/stage_sequencer.sv
// Slot sequencer that issues one-cycle fire windows to pipeline stages, with
// per-stage wait-states, flush-to-slot-0, run enable and an instruction retire counter.
`timescale 1ns/1ps
module stage_sequencer #(
  parameter int                      NSTAGE = 3,
  parameter int                      CNT_W  = 3,
  parameter int                      PERIOD = 8,
  parameter logic [NSTAGE*CNT_W-1:0] SLOTS  = {3'd5, 3'd4, 3'd0}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [NSTAGE-1:0] stage_wait,
  output logic [NSTAGE-1:0] hold,
  output logic [CNT_W-1:0]  cnt,
  output logic              busy,
  output logic              stall,
  output logic              retire,
  output logic [31:0]       retire_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NSTAGE-1:0] done_q, done_d;
  logic              retire_q, retire_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;

  logic [NSTAGE-1:0] hit;
  logic [NSTAGE-1:0] fire;
  logic              run;
  logic              stall_c;
  logic              advance;
  logic              wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= '0;
      retire_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      retire_q     <= retire_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    hit     = '0;
    fire    = '0;
    run     = (state_q == RUN);
    for (int i = 0; i < NSTAGE; i++) begin
      hit[i] = (cnt_q == SLOTS[i*CNT_W +: CNT_W]);
      // A stage already served in this slot must not fire again while others stall.
      fire[i] = run & ~flush & hit[i] & ~stage_wait[i] & ~done_q[i];
    end
    stall_c = run & ~flush & (|(hit & stage_wait));
    advance = run & ~flush & ~stall_c;
    wrap    = advance & (cnt_q == LAST);

    state_d = en ? RUN : IDLE;

    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    done_d = (flush | advance) ? '0 : (done_q | fire);

    retire_d     = wrap;
    retire_cnt_d = wrap ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  assign hold       = ~fire;
  assign cnt        = cnt_q;
  assign busy       = run;
  assign stall      = stall_c;
  assign retire     = retire_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default legacy schedule plus a
// 4-stage / period-5 instance with two stages sharing a slot.
`timescale 1ns/1ps
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, flush;
  logic [2:0]  stage_wait;
  logic [2:0]  hold;
  logic [2:0]  cnt;
  logic        busy, stall, retire;
  logic [31:0] retire_cnt;

  logic        en2, flush2;
  logic [3:0]  wait2;
  logic [3:0]  hold2;
  logic [2:0]  cnt2;
  logic        busy2, stall2, retire2;
  logic [31:0] retire_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .stage_wait(stage_wait),
    .hold(hold), .cnt(cnt), .busy(busy), .stall(stall),
    .retire(retire), .retire_cnt(retire_cnt)
  );

  stage_sequencer #(
    .NSTAGE(4), .CNT_W(3), .PERIOD(5),
    .SLOTS({3'd2, 3'd2, 3'd1, 3'd0})
  ) dut2 (
    .clk(clk), .rst(rst), .en(en2), .flush(flush2), .stage_wait(wait2),
    .hold(hold2), .cnt(cnt2), .busy(busy2), .stall(stall2),
    .retire(retire2), .retire_cnt(retire_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; stage_wait = '0;
    en2 = 1'b0; flush2 = 1'b0; wait2 = '0;
    #3;
    chk("rst_cnt", cnt, 0);
    chk("rst_hold", hold, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_retire", retire, 0);
    chk("rst_rcnt", retire_cnt, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_hold", hold, 3'b111);

    // Free run, 16 cycles, no waits.
    en = 1'b1;
    tick();
    for (int c = 0; c < 16; c++) begin
      logic [2:0] ec;
      logic [2:0] eh;
      ec = 3'(c % 8);
      eh = 3'b111;
      if (ec == 3'd0) eh[0] = 1'b0;
      if (ec == 3'd4) eh[1] = 1'b0;
      if (ec == 3'd5) eh[2] = 1'b0;
      chk("run_cnt", cnt, ec);
      chk("run_hold", hold, eh);
      chk("run_busy", busy, 1);
      chk("run_retire", retire, (c == 8) ? 1 : 0);
      tick();
    end
    chk("run_retire_end", retire, 1);
    chk("run_rcnt", retire_cnt, 2);

    // Stage 1 waits 3 cycles at slot 4.
    repeat (4) tick();
    chk("pre_wait_cnt", cnt, 4);
    stage_wait = 3'b010;
    #1;
    chk("wait1_stall", stall, 1);
    chk("wait1_hold", hold, 3'b111);
    tick();
    chk("wait2_cnt", cnt, 4);
    chk("wait2_stall", stall, 1);
    tick();
    chk("wait3_cnt", cnt, 4);
    chk("wait3_stall", stall, 1);
    tick();
    stage_wait = 3'b000;
    #1;
    chk("wait4_cnt", cnt, 4);
    chk("wait4_stall", stall, 0);
    chk("wait4_hold", hold, 3'b101);
    tick();
    chk("post_wait_hold", hold, 3'b011);
    repeat (2) tick();
    chk("pre_wrap_retire", retire, 0);
    tick();
    chk("wait_retire", retire, 1);
    chk("wait_rcnt", retire_cnt, 3);

    // Flush at slot 3.
    repeat (3) tick();
    chk("pre_flush_cnt", cnt, 3);
    flush = 1'b1;
    #1;
    chk("flush_hold", hold, 3'b111);
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_cnt", cnt, 0);
    chk("flush_retire", retire, 0);
    chk("flush_rcnt", retire_cnt, 3);
    chk("flush_refire", hold, 3'b110);

    // Pause with the counter parked at slot 2.
    tick();
    en = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("pause_cnt", cnt, 2);
      chk("pause_busy", busy, 0);
      chk("pause_hold", hold, 3'b111);
      if (c < 4) tick();
    end
    en = 1'b1;
    tick();
    chk("resume_busy", busy, 1);
    chk("resume_cnt", cnt, 2);
    chk("resume_hold0", hold, 3'b111);
    repeat (2) tick();
    chk("resume_hold2", hold, 3'b101);

    // Drop en together with flush.
    en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("enflush_busy", busy, 0);
    chk("enflush_cnt", cnt, 0);
    chk("enflush_hold", hold, 3'b111);
    en = 1'b1;
    tick();
    chk("reen_hold", hold, 3'b110);

    // Asynchronous reset mid-instruction at slot 5.
    repeat (5) tick();
    chk("pre_rst_cnt", cnt, 5);
    chk("pre_rst_hold", hold, 3'b011);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hold", hold, 3'b111);
    chk("arst_rcnt", retire_cnt, 0);
    chk("arst_retire", retire, 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Second instance: stages 2 and 3 share slot 2, stage 3 waits 2 cycles.
    en2 = 1'b1;
    tick();
    chk("s4_c0_hold", hold2, 4'b1110);
    tick();
    chk("s4_c1_hold", hold2, 4'b1101);
    tick();
    wait2 = 4'b1000;
    #1;
    chk("s4_share_hold", hold2, 4'b1011);
    chk("s4_share_stall", stall2, 1);
    tick();
    chk("s4_norefire_hold", hold2, 4'b1111);
    chk("s4_norefire_cnt", cnt2, 2);
    tick();
    wait2 = 4'b0000;
    #1;
    chk("s4_release_hold", hold2, 4'b0111);
    chk("s4_release_stall", stall2, 0);
    tick();
    chk("s4_c3_cnt", cnt2, 3);
    chk("s4_c3_hold", hold2, 4'b1111);
    tick();
    chk("s4_c4_cnt", cnt2, 4);
    tick();
    chk("s4_wrap_cnt", cnt2, 0);
    chk("s4_retire", retire2, 1);
    chk("s4_rcnt", retire_cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle stage sequencer for the RV32 core. A wrap-around slot counter issues one-cycle fire windows to N pipeline stages (fetch, memory, register writeback, and others), each at its own slot. It adds what the fixed 8-slot hold counter lacks:
- per-stage wait-states
- flush-to-slot-0
- enable/pause
- retire pulse and retire counter

It sits in the core top and drives the `hold` inputs of InstFetch, MemoryAccess, Registers and any later stages.

## Interface
- `NSTAGE`, default 3: number of sequenced stages.
- `CNT_W`, default 3: slot counter width.
- `PERIOD`, default 8: slots per instruction. Legal range is 2..2^CNT_W.
- `SLOTS`, default {3'd5, 3'd4, 3'd0}: packed NSTAGE*CNT_W vector. Field i (bits [i*CNT_W +: CNT_W]) is the fire slot of stage i. Every field must be < PERIOD. Stages may share a slot.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `flush`  in  1  abort the current instruction and restart at slot 0.
- `stage_wait`  in  NSTAGE  bit i high = stage i not ready at its slot.
- `hold`  out  NSTAGE  bit i high = stage i must hold this cycle.
- `cnt`  out  CNT_W  current slot.
- `busy`  out  1  FSM is in RUN.
- `stall`  out  1  counter frozen by a wait-state this cycle.
- `retire`  out  1  one-cycle pulse on instruction completion.
- `retire_cnt`  out  32  completed-instruction count.

## Operation
FSM has two states, IDLE and RUN.
- IDLE → RUN when en=1. RUN → IDLE when en=0.
- cnt keeps its value across the transition. Pause and resume continue from the same slot.

Combinational terms:
- `hit[i] = (cnt == SLOTS[i])`
- `fire[i] = RUN & ~flush & hit[i] & ~stage_wait[i]`
- `hold[i] = ~fire[i]`
- `stall = RUN & ~flush & |(hit & stage_wait)`

Counter update, highest priority first:
1. flush=1 → cnt←0, in any state. No stage fires in the flush cycle. No retire.
2. IDLE → cnt holds.
3. stall=1 → cnt holds. Non-waiting stages that share the current slot still fire, but only once: each stage keeps a done bit, set on fire and cleared when cnt advances. A stage with its done bit set does not re-fire.
4. Otherwise cnt←(cnt == PERIOD-1) ? 0 : cnt+1.

Retire:
- Registered. retire=1 in the cycle after a rule-4 wrap from PERIOD-1 to 0.
- retire_cnt increments on the same edge and wraps 2^32-1 → 0.
- A flush never retires.

Widths and defaults:
- cnt arithmetic is CNT_W bits. With PERIOD < 2^CNT_W, values ≥ PERIOD are never reached.
- Default parameters reproduce the legacy schedule: IF fires at slot 0, MEM at 4, REG at 5.

## Timing
- Reset (rst=0, asynchronous):
  - Registers: state=IDLE, cnt=0, done bits=0, retire=0, retire_cnt=0.
  - Resulting outputs: hold=all ones, busy=0, stall=0.
- Leaving reset: registers are released on the first clk edge after rst rises. Any deassertion-to-clock synchronisation is the top level's job.
- en high at edge k → RUN from cycle k+1. Stage 0 (slot 0) fires in cycle k+1 if stage_wait[0]=0.
- Instruction latency with no waits: PERIOD cycles. Each wait cycle adds exactly 1.
- hold and stall are combinational from cnt, state, flush and stage_wait. No added latency.
- flush in cycle k → cnt=0 in cycle k+1. A simultaneous flush and stall resolves to flush.
- en=0 together with flush → IDLE with cnt=0.
- Reset mid-instruction → immediate return to reset values. No retire pulse.

## Test plan
- Default params, en=1, waits=0, 16 cycles:
  - hold[0] low at cnt 0, hold[1] low at 4, hold[2] low at 5, all other cycles high.
  - retire pulses at cycles 8 and 16. retire_cnt=2.
- stage_wait[1]=1 for 3 cycles at cnt=4:
  - cnt stays 4 and stall=1 for 3 cycles.
  - hold[1] falls on the 4th cycle.
  - retire is delayed to cycle 11.
- flush at cnt=3:
  - cnt=0 next cycle, no retire, retire_cnt unchanged.
  - stage 0 refires at slot 0.
- en dropped at cnt=2 for 5 cycles:
  - busy=0, hold=all ones, cnt stays 2.
  - On resume, stage 1 fires 2 cycles later.
- NSTAGE=4, PERIOD=5, SLOTS={2,2,1,0}, stage_wait[3]=1 for 2 cycles at slot 2:
  - stage 2 fires once in the first slot-2 cycle and does not refire.
  - stage 3 fires when its wait drops.
- rst pulsed low mid-instruction with cnt=5:
  - All outputs take reset values asynchronously, before the next clk edge.
  - retire_cnt=0.
